// File: rtl/gpu_fb_pkg.sv
// Shared constants for the framebuffer port-B arbiter: frame geometry,
// coordinate widths, arbiter state encoding and last-grant flag encoding.
package gpu_fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int FB_XW     = 9;
  localparam int FB_YW     = 8;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_HOST_WAIT    = 2'd1;
  localparam logic [1:0] ST_FILL_WAIT    = 2'd2;
  localparam logic [1:0] ST_FILL_RD_WAIT = 2'd3;

  // Which requester owned the most recent RAM access
  localparam logic GRANT_HOST = 1'b0;
  localparam logic GRANT_FILL = 1'b1;

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle walker for the fill engine: latches the corners on load,
// orders them so lo <= hi, clips them to the visible frame, then steps
// x fastest / y slowest each time the arbiter reports a completed write.
module fb_rect_walker
  import gpu_fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int XW     = FB_XW,
  parameter int YW     = FB_YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] x1_i,
  input  logic [YW-1:0] y0_i,
  input  logic [YW-1:0] y1_i,
  input  logic          advance_i,
  output logic          busy_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic          busy_q;
  logic [XW-1:0] x_q, xlo_q, xhi_q;
  logic [YW-1:0] y_q, ylo_q, yhi_q;
  logic [XW-1:0] xlo_d, xhi_d;
  logic [YW-1:0] ylo_d, yhi_d;

  function automatic logic [XW-1:0] sat_x(input logic [XW-1:0] v);
    return (v > XW'(WIDTH - 1)) ? XW'(WIDTH - 1) : v;
  endfunction

  function automatic logic [YW-1:0] sat_y(input logic [YW-1:0] v);
    return (v > YW'(HEIGHT - 1)) ? YW'(HEIGHT - 1) : v;
  endfunction

  // Normalise corner order first, then clip each corner to the frame
  always_comb begin
    xlo_d = sat_x((x0_i <= x1_i) ? x0_i : x1_i);
    xhi_d = sat_x((x0_i <= x1_i) ? x1_i : x0_i);
    ylo_d = sat_y((y0_i <= y1_i) ? y0_i : y1_i);
    yhi_d = sat_y((y0_i <= y1_i) ? y1_i : y0_i);
  end

  assign last_o = (x_q == xhi_q) && (y_q == yhi_q);

  // Fill-active flag: set on load, cleared when the last pixel completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else if (load_i && !busy_q) begin
      busy_q <= 1'b1;
    end else if (advance_i && busy_q && last_o) begin
      busy_q <= 1'b0;
    end
  end

  // Corner latch and x/y scan counters
  always_ff @(posedge clk) begin
    if (load_i && !busy_q) begin
      xlo_q <= xlo_d;
      xhi_q <= xhi_d;
      ylo_q <= ylo_d;
      yhi_q <= yhi_d;
      x_q   <= xlo_d;
      y_q   <= ylo_d;
    end else if (advance_i && busy_q && !last_o) begin
      if (x_q == xhi_q) begin
        x_q <= xlo_q;
        y_q <= y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign busy_o = busy_q;
  assign x_o    = x_q;
  assign y_o    = y_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port-B arbiter. Shares the mclk-side RAM port between the
// host single-pixel register block and the rectangle-fill engine, alternating
// grants under contention so neither side waits more than one access.
// Optional build macro FB_FILL_XOR_EN adds an f_xor input that turns each
// fill pixel into an atomic read-modify-write (new = old ^ f_color).
module fb_port_arbiter
  import gpu_fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int XW     = FB_XW,
  parameter int YW     = FB_YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] h_x,
  input  logic [YW-1:0] h_y,
  input  logic          h_read,
  input  logic          h_write,
  input  logic          h_in,
  output logic          h_out,
  output logic          h_rdy,
  input  logic [XW-1:0] f_x0,
  input  logic [XW-1:0] f_x1,
  input  logic [YW-1:0] f_y0,
  input  logic [YW-1:0] f_y1,
  input  logic          f_color,
  input  logic          f_start,
`ifdef FB_FILL_XOR_EN
  input  logic          f_xor,
`endif
  output logic          f_busy,
  output logic          f_done,
  output logic [XW-1:0] x_b,
  output logic [YW-1:0] y_b,
  output logic          read_b,
  output logic          write_b,
  output logic          in_b,
  input  logic          out_b,
  input  logic          rdy_b
);

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic [XW-1:0] x_b_q, x_b_d;
  logic [YW-1:0] y_b_q, y_b_d;
  logic          in_b_q, in_b_d;
  logic          read_b_q, read_b_d;
  logic          write_b_q, write_b_d;
  logic          h_rdy_q, h_rdy_d;
  logic          h_out_q, h_out_d;
  logic          f_done_q, f_done_d;

  logic          pend_q, pend_wr_q, pend_in_q;
  logic [XW-1:0] pend_x_q;
  logic [YW-1:0] pend_y_q;
  logic          color_q;
`ifdef FB_FILL_XOR_EN
  logic          xor_q;
`endif

  logic          new_req, hreq, hwr, hin;
  logic [XW-1:0] hx;
  logic [YW-1:0] hy;
  logic          fill_load, walk_busy, walk_last, advance;
  logic          grant_host, grant_fill;
  logic [XW-1:0] walk_x;
  logic [YW-1:0] walk_y;

  // A fresh strobe is visible to the FSM in its own cycle so an uncontended
  // host access reaches the RAM one cycle after the strobe.
  assign new_req   = !pend_q && (h_read || h_write);
  assign hreq      = pend_q || new_req;
  assign hwr       = pend_q ? pend_wr_q : h_write;
  assign hin       = pend_q ? pend_in_q : h_in;
  assign hx        = pend_q ? pend_x_q  : h_x;
  assign hy        = pend_q ? pend_y_q  : h_y;
  assign fill_load = f_start && !walk_busy;

  assign grant_host = hreq && (!walk_busy || (grant_q == GRANT_FILL));
  assign grant_fill = walk_busy && !grant_host;

  fb_rect_walker #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_walker (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (fill_load),
    .x0_i     (f_x0),
    .x1_i     (f_x1),
    .y0_i     (f_y0),
    .y1_i     (f_y1),
    .advance_i(advance),
    .busy_o   (walk_busy),
    .x_o      (walk_x),
    .y_o      (walk_y),
    .last_o   (walk_last)
  );

  // Host pending flag: set on an accepted strobe, cleared on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (new_req) begin
      pend_q <= 1'b1;
    end else if ((state_q == ST_HOST_WAIT) && rdy_b) begin
      pend_q <= 1'b0;
    end
  end

  // Host request payload; write wins when both strobes arrive together
  always_ff @(posedge clk) begin
    if (new_req) begin
      pend_wr_q <= h_write;
      pend_in_q <= h_in;
      pend_x_q  <= h_x;
      pend_y_q  <= h_y;
    end
  end

  // Fill attributes captured alongside the walker corners
  always_ff @(posedge clk) begin
    if (fill_load) begin
      color_q <= f_color;
`ifdef FB_FILL_XOR_EN
      xor_q   <= f_xor;
`endif
    end
  end

  // Arbiter next-state: grant selection, bus drive and completion handling
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    x_b_d     = x_b_q;
    y_b_d     = y_b_q;
    in_b_d    = in_b_q;
    read_b_d  = 1'b0;
    write_b_d = 1'b0;
    h_rdy_d   = 1'b0;
    h_out_d   = h_out_q;
    f_done_d  = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_host) begin
          x_b_d     = hx;
          y_b_d     = hy;
          in_b_d    = hin;
          read_b_d  = !hwr;
          write_b_d = hwr;
          grant_d   = GRANT_HOST;
          state_d   = ST_HOST_WAIT;
        end else if (grant_fill) begin
          x_b_d   = walk_x;
          y_b_d   = walk_y;
          grant_d = GRANT_FILL;
`ifdef FB_FILL_XOR_EN
          if (xor_q) begin
            read_b_d = 1'b1;
            state_d  = ST_FILL_RD_WAIT;
          end else begin
            in_b_d    = color_q;
            write_b_d = 1'b1;
            state_d   = ST_FILL_WAIT;
          end
`else
          in_b_d    = color_q;
          write_b_d = 1'b1;
          state_d   = ST_FILL_WAIT;
`endif
        end
      end
      ST_HOST_WAIT: begin
        if (rdy_b) begin
          h_rdy_d = 1'b1;
          h_out_d = out_b;
          state_d = ST_IDLE;
        end
      end
      ST_FILL_WAIT: begin
        if (rdy_b) begin
          advance  = 1'b1;
          f_done_d = walk_last;
          state_d  = ST_IDLE;
        end
      end
      ST_FILL_RD_WAIT: begin
`ifdef FB_FILL_XOR_EN
        // Write-back follows the read directly so no host grant can split the pair
        if (rdy_b) begin
          in_b_d    = out_b ^ color_q;
          write_b_d = 1'b1;
          state_d   = ST_FILL_WAIT;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state and registered RAM/host/fill outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= GRANT_HOST;
      x_b_q     <= '0;
      y_b_q     <= '0;
      in_b_q    <= 1'b0;
      read_b_q  <= 1'b0;
      write_b_q <= 1'b0;
      h_rdy_q   <= 1'b0;
      h_out_q   <= 1'b0;
      f_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      x_b_q     <= x_b_d;
      y_b_q     <= y_b_d;
      in_b_q    <= in_b_d;
      read_b_q  <= read_b_d;
      write_b_q <= write_b_d;
      h_rdy_q   <= h_rdy_d;
      h_out_q   <= h_out_d;
      f_done_q  <= f_done_d;
    end
  end

  assign x_b     = x_b_q;
  assign y_b     = y_b_q;
  assign in_b    = in_b_q;
  assign read_b  = read_b_q;
  assign write_b = write_b_q;
  assign h_rdy   = h_rdy_q;
  assign h_out   = h_out_q;
  assign f_done  = f_done_q;
  assign f_busy  = walk_busy;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: stimulus pushes the expected RAM
// accesses and host responses; a negedge monitor pops and compares them.
module tb_fb_port_arbiter;
  localparam int XW = 9;
  localparam int YW = 8;

  typedef struct {
    bit          wr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic        d;
  } acc_t;

  typedef struct {
    bit   chk;
    logic v;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] h_x = '0;
  logic [YW-1:0] h_y = '0;
  logic          h_read = 1'b0, h_write = 1'b0, h_in = 1'b0;
  logic          h_out, h_rdy;
  logic [XW-1:0] f_x0 = '0, f_x1 = '0;
  logic [YW-1:0] f_y0 = '0, f_y1 = '0;
  logic          f_color = 1'b0, f_start = 1'b0;
`ifdef FB_FILL_XOR_EN
  logic          f_xor = 1'b0;
`endif
  logic          f_busy, f_done;
  logic [XW-1:0] x_b;
  logic [YW-1:0] y_b;
  logic          read_b, write_b, in_b, out_b, rdy_b;

  always #5 clk = ~clk;

  fb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .h_x(h_x), .h_y(h_y), .h_read(h_read), .h_write(h_write), .h_in(h_in),
    .h_out(h_out), .h_rdy(h_rdy),
    .f_x0(f_x0), .f_x1(f_x1), .f_y0(f_y0), .f_y1(f_y1),
    .f_color(f_color), .f_start(f_start),
`ifdef FB_FILL_XOR_EN
    .f_xor(f_xor),
`endif
    .f_busy(f_busy), .f_done(f_done),
    .x_b(x_b), .y_b(y_b), .read_b(read_b), .write_b(write_b), .in_b(in_b),
    .out_b(out_b), .rdy_b(rdy_b)
  );

  // RAM model: one-cycle completion after each strobe
  bit   mem [0:131071];
  logic rdy_q = 1'b0, out_q = 1'b0, stray = 1'b0;
  assign rdy_b = rdy_q | stray;
  assign out_b = out_q;
  always @(posedge clk) begin
    rdy_q <= read_b | write_b;
    if (read_b)  out_q <= mem[{y_b, x_b}];
    if (write_b) mem[{y_b, x_b}] <= in_b;
  end

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int n_cmp = 0, n_bad = 0, n_acc = 0, n_rdy = 0, n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_a(input bit wr, input int x, input int y, input bit d);
    acc_t e;
    e.wr = wr; e.x = XW'(x); e.y = YW'(y); e.d = d;
    exp_acc.push_back(e);
  endtask

  // Monitor: compares every RAM strobe and host completion against the queues
  bit            outst = 1'b0;
  logic [XW-1:0] hold_x;
  logic [YW-1:0] hold_y;
  always @(negedge clk) begin
    acc_t e;
    rsp_t r;
    if (!rst_n) begin
      outst = 1'b0;
    end else begin
      if (outst && rdy_b) begin
        check("hold_x", 32'(x_b), 32'(hold_x));
        check("hold_y", 32'(y_b), 32'(hold_y));
        outst = 1'b0;
      end
      if (read_b || write_b) begin
        check("strobe_while_busy", 32'(outst), 32'd0);
        n_acc++;
        if (exp_acc.size() == 0) begin
          fail_now($sformatf("unexpected_access x=%0d y=%0d wr=%0d", x_b, y_b, write_b));
        end else begin
          e = exp_acc.pop_front();
          check("acc_wr", 32'(write_b), 32'(e.wr));
          check("acc_rd", 32'(read_b), 32'(!e.wr));
          check("acc_x", 32'(x_b), 32'(e.x));
          check("acc_y", 32'(y_b), 32'(e.y));
          if (e.wr) check("acc_data", 32'(in_b), 32'(e.d));
        end
        outst = 1'b1;
        hold_x = x_b;
        hold_y = y_b;
      end
      if (h_rdy) begin
        n_rdy++;
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_h_rdy");
        end else begin
          r = exp_rsp.pop_front();
          if (r.chk) check("h_out", 32'(h_out), 32'(r.v));
        end
      end
      if (f_done) n_done++;
    end
  end

  task automatic host(input bit wr, input int x, input int y, input bit d,
                      input bit chk, input bit ev);
    rsp_t r;
    exp_a(wr, x, y, d);
    r.chk = chk; r.v = ev;
    exp_rsp.push_back(r);
    h_x = XW'(x); h_y = YW'(y); h_in = d;
    h_write = wr; h_read = !wr;
    @(negedge clk);
    h_write = 1'b0; h_read = 1'b0;
  endtask

  task automatic fill_start(input int x0, input int y0, input int x1, input int y1, input bit c);
    f_x0 = XW'(x0); f_y0 = YW'(y0); f_x1 = XW'(x1); f_y1 = YW'(y1);
    f_color = c;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (exp_acc.size() == 0 && exp_rsp.size() == 0 && !f_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now({name, "_timeout"});
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_hrdy();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (h_rdy) return;
    end
    fail_now("h_rdy_timeout");
  endtask

  initial begin
    int d0, r0, a0;
    bit seen;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({x_b, y_b, in_b, read_b, write_b, h_out, h_rdy, f_busy, f_done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Host write (5,7)=1 : strobe appears the next cycle
    r0 = n_rdy;
    exp_a(1'b1, 5, 7, 1'b1);
    exp_rsp.push_back('{chk: 1'b0, v: 1'b0});
    h_x = 9'd5; h_y = 8'd7; h_in = 1'b1; h_write = 1'b1;
    @(negedge clk);
    h_write = 1'b0;
    check("wr_latency", 32'(write_b), 32'd1);
    check("wr_latency_x", 32'(x_b), 32'd5);
    drain("host_write");
    check("host_write_rdy_cnt", 32'(n_rdy - r0), 32'd1);

    // Host read back (5,7) -> 1
    host(1'b0, 5, 7, 1'b0, 1'b1, 1'b1);
    drain("host_read");

    // Basic fill with swapped corners
    d0 = n_done;
    exp_a(1'b1, 10, 20, 1'b1); exp_a(1'b1, 11, 20, 1'b1);
    exp_a(1'b1, 10, 21, 1'b1); exp_a(1'b1, 11, 21, 1'b1);
    fill_start(11, 21, 10, 20, 1'b1);
    check("fill_busy_rise", 32'(f_busy), 32'd1);
    drain("basic_fill");
    check("basic_fill_done_cnt", 32'(n_done - d0), 32'd1);
    check("basic_fill_busy_low", 32'(f_busy), 32'd0);
    host(1'b0, 11, 21, 1'b0, 1'b1, 1'b1);
    drain("read_filled");

    // Contention: strict H,F alternation
    d0 = n_done;
    exp_a(1'b1, 1, 1, 1'b1); exp_a(1'b1, 0, 0, 1'b0);
    exp_a(1'b1, 1, 1, 1'b1); exp_a(1'b1, 1, 0, 1'b0);
    exp_a(1'b1, 1, 1, 1'b1); exp_a(1'b1, 0, 1, 1'b0);
    exp_a(1'b1, 1, 1, 1'b1); exp_a(1'b1, 1, 1, 1'b0);
    for (int i = 0; i < 4; i++) exp_rsp.push_back('{chk: 1'b0, v: 1'b0});
    f_x0 = 9'd0; f_y0 = 8'd0; f_x1 = 9'd1; f_y1 = 8'd1; f_color = 1'b0; f_start = 1'b1;
    h_x = 9'd1; h_y = 8'd1; h_in = 1'b1; h_write = 1'b1;
    @(negedge clk);
    f_start = 1'b0; h_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_hrdy();
      h_write = 1'b1;
      @(negedge clk);
      h_write = 1'b0;
    end
    drain("contention");
    check("contention_done_cnt", 32'(n_done - d0), 32'd1);

    // Clipping to the frame edge
    d0 = n_done;
    exp_a(1'b1, 318, 198, 1'b1); exp_a(1'b1, 319, 198, 1'b1);
    exp_a(1'b1, 318, 199, 1'b1); exp_a(1'b1, 319, 199, 1'b1);
    fill_start(318, 198, 400, 250, 1'b1);
    drain("clip_fill");
    check("clip_done_cnt", 32'(n_done - d0), 32'd1);

    // Stray rdy_b while idle is ignored
    r0 = n_rdy; d0 = n_done; a0 = n_acc;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_h_rdy", 32'(n_rdy - r0), 32'd0);
    check("stray_f_done", 32'(n_done - d0), 32'd0);
    check("stray_access", 32'(n_acc - a0), 32'd0);

    // Reset after 2 of 9 fill pixels
    exp_a(1'b1, 20, 30, 1'b1); exp_a(1'b1, 21, 30, 1'b1);
    a0 = n_acc;
    fill_start(20, 30, 22, 32, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (n_acc == a0 + 2) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("reset_fill_progress_timeout");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outs", 32'({x_b, y_b, in_b, read_b, write_b, h_out, h_rdy, f_busy, f_done}), 32'd0);
    check("midreset_queue", 32'(exp_acc.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d0 = n_done;
    exp_a(1'b1, 5, 5, 1'b1); exp_a(1'b1, 6, 5, 1'b1);
    fill_start(6, 5, 5, 5, 1'b1);
    drain("post_reset_fill");
    check("post_reset_done_cnt", 32'(n_done - d0), 32'd1);
    check("post_reset_busy_low", 32'(f_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
